// File: rtl/fetch_prefetch.sv
// fetch_prefetch: PC generator with a DEPTH-entry {PC, instruction} prefetch queue toward decode
// Ports: clk, reset (sync, active-low); PCSrc_F/PCBranch_F redirect and flush;
// imem_addr_F/imem_data_F combinational instruction-memory access;
// instr_D/pc_D/valid_D queue head toward decode, ready_D decode accept.
module fetch_prefetch #(
    parameter int N = 64,
    parameter int DEPTH = 4,
    parameter int INC = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc_F,
    input  logic [N-1:0] PCBranch_F,
    output logic [N-1:0] imem_addr_F,
    input  logic [31:0]  imem_data_F,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    input  logic         ready_D
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [N-1:0]  pc;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pc_mem [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic          pop, push;
    always_comb begin
        valid_D     = cnt != '0;
        pop         = valid_D & ready_D;
        push        = !PCSrc_F & (cnt < CW'(DEPTH) | pop);
        imem_addr_F = pc;
        instr_D     = valid_D ? ins_mem[rp] : '0;
        pc_D        = valid_D ? pc_mem[rp] : '0;
    end
    // flush beats any same-cycle pop; reset beats everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc  <= RESET_PC;
            cnt <= '0;
            wp  <= '0;
            rp  <= '0;
        end else if (PCSrc_F) begin
            pc  <= {PCBranch_F[N-1:2], 2'b00};
            cnt <= '0;
            wp  <= '0;
            rp  <= '0;
        end else begin
            if (push) begin
                pc <= pc + N'(INC);
                wp <= wp + AW'(1);
            end
            if (pop)
                rp <= rp + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    // storage is never cleared; pointers alone define the live entries
    always_ff @(posedge clk) begin
        if (reset && push) begin
            pc_mem[wp]  <= pc;
            ins_mem[wp] <= imem_data_F;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed + randomized checking of fetch_prefetch against a queue-based model
module tb_fetch_prefetch;
    localparam int N = 8;
    localparam int DEPTH = 4;
    localparam int INC = 4;
    localparam logic [N-1:0] RST_PC = 8'hF8;

    logic         clk = 0;
    logic         reset = 0;
    logic         pcsrc = 0;
    logic [N-1:0] tgt = '0;
    logic         rdy = 0;
    logic [N-1:0] imem_addr, pc_d;
    logic [31:0]  imem_data, instr_d;
    logic         valid_d;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  m_pc;
    logic [39:0]   q[$];

    always #5 clk = ~clk;

    assign imem_data = 32'h1000 + {24'd0, imem_addr};

    fetch_prefetch #(.N(N), .DEPTH(DEPTH), .INC(INC), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(tgt),
        .imem_addr_F(imem_addr), .imem_data_F(imem_data),
        .instr_D(instr_d), .pc_D(pc_d), .valid_D(valid_d), .ready_D(rdy)
    );

    function automatic logic [31:0] mem(input logic [N-1:0] a);
        return 32'h1000 + {24'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [N-1:0] t, input logic y);
        logic pop, push;
        reset = r; pcsrc = s; tgt = t; rdy = y;
        if (!r) begin
            m_pc = RST_PC;
            q.delete();
        end else if (s) begin
            m_pc = {t[N-1:2], 2'b00};
            q.delete();
        end else begin
            pop  = q.size() > 0 && y;
            push = q.size() < DEPTH || pop;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back({m_pc, mem(m_pc)});
                m_pc = m_pc + N'(INC);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("imem_addr", 40'(imem_addr), 40'(m_pc));
        chk("valid_D", 40'(valid_d), 40'(q.size() > 0));
        chk("pc_D", 40'(pc_d), q.size() > 0 ? 40'(q[0][39:32]) : 40'd0);
        chk("instr_D", 40'(instr_d), q.size() > 0 ? 40'(q[0][31:0]) : 40'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
        step(1, 1, 8'h00, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        chk("full_hold_addr", 40'(imem_addr), 40'h10);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 1, 8'h83, 0);
        chk("redirect_addr", 40'(imem_addr), 40'h80);
        chk("redirect_flush", 40'(valid_d), 40'd0);
        step(1, 0, 0, 0);
        chk("redirect_head", 40'(pc_d), 40'h80);
        step(1, 0, 0, 0);
        step(1, 1, 8'h40, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 0, 0, i[0]);
        step(1, 1, 8'h40, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 1, 8'h20, 1);
        chk("midop_reset_addr", 40'(imem_addr), 40'(RST_PC));
        chk("midop_reset_valid", 40'(valid_d), 40'd0);
        for (int seg = 0; seg < 40; seg++) begin
            int bias = $urandom_range(0, 4);
            for (int i = 0; i < 10; i++)
                step(($urandom % 60) != 0, ($urandom % 15) == 0, N'($urandom),
                     $urandom_range(0, 3) < bias);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
